// File: rtl/button_event_pkg.sv
// rtl/button_event_pkg.sv - state encoding and event codes shared by the button event classifier
package button_event_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE      = 3'd0;
  localparam state_t ST_PRESS1    = 3'd1;
  localparam state_t ST_LONG_HELD = 3'd2;
  localparam state_t ST_GAP       = 3'd3;
  localparam state_t ST_PRESS2    = 3'd4;

  localparam logic [1:0] EV_NONE   = 2'b00;
  localparam logic [1:0] EV_SHORT  = 2'b01;
  localparam logic [1:0] EV_LONG   = 2'b10;
  localparam logic [1:0] EV_DOUBLE = 2'b11;

  function automatic logic is_pressed(input state_t s);
    return (s == ST_PRESS1) || (s == ST_LONG_HELD) || (s == ST_PRESS2);
  endfunction

endpackage

// File: rtl/button_event_classifier.sv
// rtl/button_event_classifier.sv - classifies debounced presses into short, long and double-click events
module button_event_classifier
  import button_event_pkg::*;
#(
  parameter int LONG_CYCLES = 50_000_000,
  parameter int GAP_CYCLES  = 25_000_000,
  parameter int CNT_W       = 26
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       debounced,
  input  logic       event_ack,
  output logic       event_valid,
  output logic [1:0] event_code,
  output logic       event_overrun,
  output logic       held
);

  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);

  state_t           state;
  state_t           next_state;
  logic [CNT_W-1:0] cnt;
  logic             raise;
  logic [1:0]       raise_code;

  always_comb begin
    next_state = state;
    raise      = 1'b0;
    raise_code = EV_NONE;
    case (state)
      ST_IDLE: begin
        if (debounced) next_state = ST_PRESS1;
      end
      ST_PRESS1: begin
        if (!debounced) begin
          next_state = ST_GAP;
        end else if (cnt == LONG_LAST) begin
          next_state = ST_LONG_HELD;
          raise      = 1'b1;
          raise_code = EV_LONG;
        end
      end
      ST_LONG_HELD: begin
        if (!debounced) next_state = ST_IDLE;
      end
      ST_GAP: begin
        // A press arriving in the timeout cycle still counts as the second click.
        if (debounced) begin
          next_state = ST_PRESS2;
        end else if (cnt == GAP_LAST) begin
          next_state = ST_IDLE;
          raise      = 1'b1;
          raise_code = EV_SHORT;
        end
      end
      ST_PRESS2: begin
        if (!debounced) begin
          next_state = ST_IDLE;
          raise      = 1'b1;
          raise_code = EV_DOUBLE;
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= ST_IDLE;
      cnt           <= '0;
      held          <= 1'b0;
      event_valid   <= 1'b0;
      event_code    <= EV_NONE;
      event_overrun <= 1'b0;
    end else begin
      state <= next_state;
      held  <= is_pressed(next_state);

      if (next_state != state) begin
        cnt <= '0;
      end else if (state == ST_PRESS1 || state == ST_GAP) begin
        cnt <= cnt + CNT_W'(1);
      end

      // An ack in the raise cycle frees the slot, so the new event replaces the old one.
      if (raise) begin
        if (!event_valid || event_ack) begin
          event_valid <= 1'b1;
          event_code  <= raise_code;
        end else begin
          event_overrun <= 1'b1;
        end
      end else if (event_valid && event_ack) begin
        event_valid <= 1'b0;
        event_code  <= EV_NONE;
      end
    end
  end

endmodule

// File: tb/tb_button_event_classifier.sv
// tb/tb_button_event_classifier.sv - directed bench for button_event_classifier
module tb_button_event_classifier;

  logic       clk = 1'b0;
  logic       reset;
  logic       debounced;
  logic       event_ack;
  logic       event_valid;
  logic [1:0] event_code;
  logic       event_overrun;
  logic       held;

  int tests_run = 0;
  int tests_failed = 0;

  button_event_classifier #(
    .LONG_CYCLES(8),
    .GAP_CYCLES (4),
    .CNT_W      (4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .debounced    (debounced),
    .event_ack    (event_ack),
    .event_valid  (event_valid),
    .event_code   (event_code),
    .event_overrun(event_overrun),
    .held         (held)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic ack_pulse();
    event_ack = 1'b1;
    step(1);
    event_ack = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    debounced = 1'b0;
    event_ack = 1'b0;
    step(2);
    check("rst_valid", event_valid, 0);
    check("rst_code", event_code, 0);
    check("rst_overrun", event_overrun, 0);
    check("rst_held", held, 0);
    reset = 1'b0;
    step(1);

    // Short press: 3 high edges, then the gap runs out
    debounced = 1'b1;
    step(1);
    check("short_held", held, 1);
    step(2);
    debounced = 1'b0;
    step(4);
    check("short_pre_valid", event_valid, 0);
    step(1);
    check("short_valid", event_valid, 1);
    check("short_code", event_code, 2'b01);
    check("short_held_off", held, 0);
    ack_pulse();
    check("short_ack_valid", event_valid, 0);
    check("short_ack_code", event_code, 0);

    // Ack with nothing pending is ignored
    ack_pulse();
    check("idle_ack_valid", event_valid, 0);
    check("idle_ack_overrun", event_overrun, 0);

    // Long press: 20 high edges, event visible after the 9th
    debounced = 1'b1;
    step(8);
    check("long_pre_valid", event_valid, 0);
    check("long_held8", held, 1);
    step(1);
    check("long_valid", event_valid, 1);
    check("long_code", event_code, 2'b10);
    ack_pulse();
    step(10);
    check("long_single_event", event_valid, 0);
    check("long_held20", held, 1);
    debounced = 1'b0;
    step(1);
    check("long_release_held", held, 0);
    check("long_release_valid", event_valid, 0);

    // Double click
    debounced = 1'b1; step(2);
    debounced = 1'b0; step(2);
    debounced = 1'b1; step(2);
    check("dbl_pre_valid", event_valid, 0);
    check("dbl_held", held, 1);
    debounced = 1'b0; step(1);
    check("dbl_valid", event_valid, 1);
    check("dbl_code", event_code, 2'b11);
    step(6);
    check("dbl_no_short", event_code, 2'b11);
    ack_pulse();

    // Second press lands in the gap timeout cycle
    debounced = 1'b1; step(2);
    debounced = 1'b0; step(4);
    debounced = 1'b1; step(1);
    check("gapb_no_short", event_valid, 0);
    check("gapb_held", held, 1);
    step(2);
    debounced = 1'b0; step(1);
    check("gapb_valid", event_valid, 1);
    check("gapb_code", event_code, 2'b11);
    step(6);
    check("gapb_code_hold", event_code, 2'b11);
    check("gapb_overrun", event_overrun, 0);
    ack_pulse();

    // Overrun: unacked short, then a long press
    debounced = 1'b1; step(3);
    debounced = 1'b0; step(5);
    check("ovr_short_code", event_code, 2'b01);
    debounced = 1'b1; step(9);
    check("ovr_flag", event_overrun, 1);
    check("ovr_code_kept", event_code, 2'b01);
    check("ovr_valid", event_valid, 1);
    debounced = 1'b0; step(1);
    ack_pulse();
    check("ovr_ack_valid", event_valid, 0);
    check("ovr_sticky", event_overrun, 1);
    reset = 1'b1; step(1);
    check("ovr_rst_clear", event_overrun, 0);
    reset = 1'b0; step(1);

    // Ack in the long-raise cycle: replacement, no overrun
    debounced = 1'b1; step(3);
    debounced = 1'b0; step(5);
    check("rep_short_code", event_code, 2'b01);
    debounced = 1'b1; step(8);
    event_ack = 1'b1; step(1); event_ack = 1'b0;
    check("rep_valid", event_valid, 1);
    check("rep_code", event_code, 2'b10);
    check("rep_overrun", event_overrun, 0);
    debounced = 1'b0; step(1);
    ack_pulse();

    // Reset mid-PRESS1 with the button still held
    debounced = 1'b1; step(3);
    check("mid_held", held, 1);
    reset = 1'b1; #1;
    check("mid_rst_held", held, 0);
    check("mid_rst_valid", event_valid, 0);
    check("mid_rst_code", event_code, 0);
    check("mid_rst_overrun", event_overrun, 0);
    step(2);
    reset = 1'b0;
    step(8);
    check("mid_pre_valid", event_valid, 0);
    step(1);
    check("mid_long_valid", event_valid, 1);
    check("mid_long_code", event_code, 2'b10);
    debounced = 1'b0; step(1);
    ack_pulse();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/button_event_classifier.md
BUTTON_EVENT_CLASSIFIER -- requirements
Module: button_event_classifier

Interface
REQ-001 Parameter LONG_CYCLES, default 50_000_000, press duration in clk cycles that classifies a long press (>=2).
REQ-002 Parameter GAP_CYCLES, default 25_000_000, maximum release-to-second-press gap in clk cycles for a double click (>=2).
REQ-003 Parameter CNT_W, default 26, duration counter width; must hold max(LONG_CYCLES, GAP_CYCLES)-1.
REQ-004 clk  input  1  system clock; all logic is on the rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 debounced  input  1  debounced button level from the debouncer stage, synchronous to clk, 1 = pressed.
REQ-007 event_ack  input  1  consumer acknowledge of the pending event.
REQ-008 event_valid  output  1  a classified event is pending.
REQ-009 event_code  output  2  01 short, 10 long, 11 double; 00 when none.
REQ-010 event_overrun  output  1  sticky flag: an event was lost because the previous one was not acknowledged.
REQ-011 held  output  1  level: the button is currently pressed in any pressed state.

Function
REQ-012 The FSM has states IDLE, PRESS1, LONG_HELD, GAP and PRESS2; the duration counter clears on every state change.
REQ-013 In IDLE, debounced=1 moves to PRESS1.
REQ-014 In PRESS1, the counter increments each cycle; debounced=0 moves to GAP; when counter=LONG_CYCLES-1 and debounced=1, the FSM moves to LONG_HELD and raises a long event.
REQ-015 In LONG_HELD, debounced=0 moves to IDLE; no further event is raised.
REQ-016 In GAP, the counter increments; debounced=1 moves to PRESS2; when counter=GAP_CYCLES-1 and debounced=0, the FSM moves to IDLE and raises a short event.
REQ-017 If the GAP timeout and debounced=1 fall in the same cycle, the press wins: the FSM moves to PRESS2 and raises no short event.
REQ-018 In PRESS2, debounced=0 moves to IDLE and raises a double event, whatever the press duration.
REQ-019 An event is raised in cycle N when its transition condition is sampled; event_valid and event_code are registered and appear in cycle N+1.
REQ-020 event_valid and event_code hold until a cycle with event_ack=1 while event_valid=1; event_valid and event_code then clear on the next edge.
REQ-021 event_ack while event_valid=0 is ignored.
REQ-022 An event raised while event_valid=1 and event_ack=0 is dropped, and event_overrun sets on the next edge; the pending code is retained.
REQ-023 An event raised in the same cycle as event_ack on a pending event replaces the pending event with no overrun; event_valid stays 1.
REQ-024 event_overrun clears only on reset.
REQ-025 held is registered and equals 1 exactly when the state is PRESS1, LONG_HELD or PRESS2.
REQ-026 The counter does not wrap, because each timed state exits at its terminal count.

Reset
REQ-027 Asserting reset, at any time including mid-press, forces state IDLE, counter 0, event_valid 0, event_code 00, event_overrun 0 and held 0.
REQ-028 After reset is released with debounced=1, the FSM moves to PRESS1 on the first edge, so the press is timed from release.

Structure
REQ-029 A shared package button_event_pkg holds the state encoding (3-bit localparams) and the event code constants EV_NONE, EV_SHORT, EV_LONG and EV_DOUBLE.
REQ-030 The design is a single module with no sub-module; the counter and the event register are inline.

Verification
REQ-031 All scenarios use LONG_CYCLES=8, GAP_CYCLES=4 and CNT_W=4.
REQ-032 Short press: debounced high 3 cycles, then low -> after 4 low cycles event_valid=1 with code 01; ack -> valid 0 and code 00 on the next edge.
REQ-033 Long press: debounced high 20 cycles -> code 10 exactly 9 cycles after the rise, only one event; held=1 for 20 cycles.
REQ-034 Double click: high 2, low 2, high 2, low -> code 11 one cycle after the second release; no short event.
REQ-035 Gap boundary: high 2, low exactly 3 cycles, then high in the timeout cycle -> PRESS2, no code 01; release -> code 11.
REQ-036 Overrun: short event left unacked, then a long press -> event_overrun=1 and code stays 01; the same sequence with ack in the long-raise cycle -> code 10 and overrun 0.
REQ-037 Reset mid-PRESS1: all outputs at reset values; with debounced still high after release, code 10 arrives 9 cycles after reset deasserts.
